// File: rtl/scalar_wb_arbiter_pkg.sv
// scalar_pkg: shared widths, register-zero constant and the writeback entry type
package scalar_pkg;
   localparam int SCALAR_DATA_W = 32;
   localparam int SCALAR_ADDR_W = 4;
   localparam int SCALAR_NREGS = 16;
   localparam logic [SCALAR_ADDR_W-1:0] REG_ZERO = '0;
   typedef struct packed {
      logic [SCALAR_ADDR_W-1:0] rd;
      logic [SCALAR_DATA_W-1:0] data;
   } wb_entry_t;
endpackage

// File: rtl/scalar_wb_arbiter_if.sv
// scalar_wb_arbiter_if: ALU/memory producer handshakes and register-file write port
interface scalar_wb_arbiter_if
   import scalar_pkg::*;
#(
   parameter int DATA_W = SCALAR_DATA_W,
   parameter int ADDR_W = SCALAR_ADDR_W
);
   logic alu_valid;
   logic alu_ready;
   logic [ADDR_W-1:0] alu_rd;
   logic [DATA_W-1:0] alu_data;
   logic mem_valid;
   logic [ADDR_W-1:0] mem_rd;
   logic [DATA_W-1:0] mem_data;
   logic rf_wr_enable;
   logic [ADDR_W-1:0] rf_rd;
   logic [DATA_W-1:0] rf_wd;
   modport master (
      output alu_valid, alu_rd, alu_data, mem_valid, mem_rd, mem_data,
      input alu_ready, rf_wr_enable, rf_rd, rf_wd
   );
   modport slave (
      input alu_valid, alu_rd, alu_data, mem_valid, mem_rd, mem_data,
      output alu_ready, rf_wr_enable, rf_rd, rf_wd
   );
endinterface

// File: rtl/scalar_wb_arbiter_fifo.sv
// wb_fifo: in-order holding FIFO for ALU results that lost the write port,
// exposing per-slot valid/rd so the top can build the busy mask
module wb_fifo
   import scalar_pkg::*;
#(
   parameter int DEPTH = 4,
   localparam int PW = $clog2(DEPTH)
) (
   input  logic clk,
   input  logic rst,
   input  logic push,
   input  logic pop,
   input  wb_entry_t wr_entry,
   output wb_entry_t head,
   output logic full,
   output logic empty,
   output logic [PW:0] level,
   output logic [DEPTH-1:0] ent_valid,
   output logic [DEPTH-1:0][SCALAR_ADDR_W-1:0] ent_rd
);
   wb_entry_t mem [DEPTH];
   logic [PW-1:0] wr_ptr, rd_ptr;
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         level <= '0;
      end else begin
         if (push) wr_ptr <= wr_ptr + PW'(1);
         if (pop) rd_ptr <= rd_ptr + PW'(1);
         level <= level + (PW+1)'(push) - (PW+1)'(pop);
      end
   end
   always_ff @(posedge clk) begin
      if (push) mem[wr_ptr] <= wr_entry;
   end
   assign head = mem[rd_ptr];
   assign full = level == (PW+1)'(DEPTH);
   assign empty = level == '0;
   // A slot is live when its distance from the read pointer is below the occupancy
   always_comb begin
      for (int i = 0; i < DEPTH; i++) begin
         ent_valid[i] = {1'b0, PW'(PW'(i) - rd_ptr)} < level;
         ent_rd[i] = mem[i].rd;
      end
   end
endmodule

// File: rtl/scalar_wb_arbiter.sv
// scalar_wb_arbiter: merges memory load responses and ALU results onto the single
// register-file write port; memory always wins, losing ALU results queue in order
module scalar_wb_arbiter
   import scalar_pkg::*;
#(
   parameter int DATA_W = SCALAR_DATA_W,
   parameter int ADDR_W = $clog2(SCALAR_NREGS),
   parameter int DEPTH = 4
) (
   input  logic clk,
   input  logic rst,
   scalar_wb_arbiter_if.slave bus,
   output logic [2**ADDR_W-1:0] busy,
   output logic [$clog2(DEPTH):0] fifo_level
);
   wb_entry_t head, push_entry;
   logic full, empty, accept, push, pop, selected;
   logic [DEPTH-1:0] ent_valid;
   logic [DEPTH-1:0][SCALAR_ADDR_W-1:0] ent_rd;
   logic [ADDR_W-1:0] sel_rd;
   logic [DATA_W-1:0] sel_data;
   // Ready uses registered occupancy, so a full FIFO refuses even when popping
   assign bus.alu_ready = rst & ~full;
   assign accept = bus.alu_valid & bus.alu_ready;
   assign pop = ~bus.mem_valid & ~empty;
   assign push = accept & (bus.mem_valid | ~empty);
   assign selected = bus.mem_valid | ~empty | accept;
   assign sel_rd = bus.mem_valid ? bus.mem_rd : !empty ? head.rd : bus.alu_rd;
   assign sel_data = bus.mem_valid ? bus.mem_data : !empty ? head.data : bus.alu_data;
   assign push_entry = '{rd: bus.alu_rd, data: bus.alu_data};
   wb_fifo #(.DEPTH(DEPTH)) u_fifo (
      .clk(clk),
      .rst(rst),
      .push(push),
      .pop(pop),
      .wr_entry(push_entry),
      .head(head),
      .full(full),
      .empty(empty),
      .level(fifo_level),
      .ent_valid(ent_valid),
      .ent_rd(ent_rd)
   );
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         bus.rf_wr_enable <= 1'b0;
         bus.rf_rd <= '0;
         bus.rf_wd <= '0;
      end else begin
         bus.rf_wr_enable <= selected & (sel_rd != REG_ZERO);
         if (selected) begin
            bus.rf_rd <= sel_rd;
            bus.rf_wd <= sel_data;
         end
      end
   end
   always_comb begin
      busy = '0;
      for (int i = 0; i < DEPTH; i++) if (ent_valid[i]) busy[ent_rd[i]] = 1'b1;
      if (bus.rf_wr_enable) busy[bus.rf_rd] = 1'b1;
      busy[0] = 1'b0;
   end
endmodule

// File: tb/tb_scalar_wb_arbiter.sv
// tb_scalar_wb_arbiter: random and directed stimulus against a queue-based
// reference model; expected writes go to a scoreboard drained by a write monitor
module tb_scalar_wb_arbiter;
   import scalar_pkg::*;
   localparam int DEPTH = 4;
   logic clk = 1'b0;
   logic rst = 1'b0;
   logic [15:0] busy;
   logic [2:0] fifo_level;
   logic acc;
   int k;
   scalar_wb_arbiter_if bus();
   scalar_wb_arbiter #(.DEPTH(DEPTH)) dut (
      .clk(clk),
      .rst(rst),
      .bus(bus),
      .busy(busy),
      .fifo_level(fifo_level)
   );
   always #5 clk = ~clk;
   wb_entry_t mq[$];
   wb_entry_t exp_q[$];
   logic last_v = 1'b0;
   logic [3:0] last_rd = '0;
   int n_chk = 0;
   int n_fail = 0;
   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask
   function automatic logic [15:0] model_busy();
      logic [15:0] b;
      b = '0;
      foreach (mq[i]) b[mq[i].rd] = 1'b1;
      if (last_v) b[last_rd] = 1'b1;
      b[0] = 1'b0;
      return b;
   endfunction
   always @(negedge clk) begin
      wb_entry_t e;
      if (rst && bus.rf_wr_enable) begin
         if (exp_q.size() == 0) begin
            n_chk++;
            n_fail++;
            $display("FAIL unexpected_write: got r%0d=%0h expected no write", bus.rf_rd, bus.rf_wd);
         end else begin
            e = exp_q.pop_front();
            chk("wr_rd", 64'(bus.rf_rd), 64'(e.rd));
            chk("wr_data", 64'(bus.rf_wd), 64'(e.data));
         end
      end
   end
   task automatic drive(input logic mv, input logic [3:0] mrd, input logic [31:0] md,
                        input logic av, input logic [3:0] ard, input logic [31:0] ad);
      bus.mem_valid = mv;
      bus.mem_rd = mrd;
      bus.mem_data = md;
      bus.alu_valid = av;
      bus.alu_rd = ard;
      bus.alu_data = ad;
   endtask
   task automatic step(input logic mv, input logic [3:0] mrd, input logic [31:0] md,
                       input logic av, input logic [3:0] ard, input logic [31:0] ad,
                       output logic accepted);
      wb_entry_t s;
      logic sel;
      @(negedge clk);
      chk("alu_ready", 64'(bus.alu_ready), 64'(mq.size() < DEPTH));
      chk("fifo_level", 64'(fifo_level), 64'(mq.size()));
      chk("busy", 64'(busy), 64'(model_busy()));
      drive(mv, mrd, md, av, ard, ad);
      accepted = av && mq.size() < DEPTH;
      sel = 1'b1;
      s = '0;
      if (mv) begin
         s = '{rd: mrd, data: md};
         if (accepted) mq.push_back('{rd: ard, data: ad});
      end else if (mq.size() > 0) begin
         s = mq.pop_front();
         if (accepted) mq.push_back('{rd: ard, data: ad});
      end else if (accepted) s = '{rd: ard, data: ad};
      else sel = 1'b0;
      last_v = sel && s.rd != 4'd0;
      last_rd = s.rd;
      if (last_v) exp_q.push_back(s);
   endtask
   task automatic idle(input int n);
      logic a;
      for (int i = 0; i < n; i++) step(1'b0, 4'd0, 32'd0, 1'b0, 4'd0, 32'd0, a);
   endtask
   initial begin
      drive(1'b0, 4'd0, 32'd0, 1'b0, 4'd0, 32'd0);
      #12;
      chk("rst_wr_enable", 64'(bus.rf_wr_enable), 64'd0);
      chk("rst_rf_rd", 64'(bus.rf_rd), 64'd0);
      chk("rst_rf_wd", 64'(bus.rf_wd), 64'd0);
      chk("rst_level", 64'(fifo_level), 64'd0);
      chk("rst_busy", 64'(busy), 64'd0);
      chk("rst_alu_ready", 64'(bus.alu_ready), 64'd0);
      #10 rst = 1'b1;
      step(1'b0, 4'd0, 32'd0, 1'b1, 4'd3, 32'h11, acc);
      idle(3);
      step(1'b1, 4'd5, 32'hAA, 1'b1, 4'd6, 32'hBB, acc);
      idle(4);
      step(1'b0, 4'd0, 32'd0, 1'b1, 4'd0, 32'hFF, acc);
      step(1'b0, 4'd0, 32'd0, 1'b1, 4'd2, 32'h22, acc);
      idle(3);
      k = 1;
      for (int c = 0; c < 6; c++) begin
         step(1'b1, 4'(8 + c), 32'h100 + c, 1'b1, 4'(k), 32'h200 + k, acc);
         if (acc) k++;
      end
      for (int c = 0; c < 20 && k <= 6; c++) begin
         step(1'b0, 4'd0, 32'd0, 1'b1, 4'(k), 32'h200 + k, acc);
         if (acc) k++;
      end
      chk("fill_all_accepted", 64'(k), 64'd7);
      idle(8);
      step(1'b1, 4'd10, 32'h310, 1'b1, 4'd7, 32'h407, acc);
      step(1'b1, 4'd11, 32'h311, 1'b1, 4'd8, 32'h408, acc);
      step(1'b1, 4'd12, 32'h312, 1'b1, 4'd9, 32'h409, acc);
      @(posedge clk);
      #2 rst = 1'b0;
      #1;
      chk("arst_wr_enable", 64'(bus.rf_wr_enable), 64'd0);
      chk("arst_busy", 64'(busy), 64'd0);
      chk("arst_level", 64'(fifo_level), 64'd0);
      chk("arst_alu_ready", 64'(bus.alu_ready), 64'd0);
      chk("arst_rf_rd", 64'(bus.rf_rd), 64'd0);
      mq.delete();
      exp_q.delete();
      last_v = 1'b0;
      drive(1'b0, 4'd0, 32'd0, 1'b0, 4'd0, 32'd0);
      @(negedge clk);
      #3 rst = 1'b1;
      idle(4);
      for (int i = 0; i < 600; i++) begin
         int pm;
         pm = (i % 100 < 50) ? 60 : 15;
         step($urandom_range(0, 99) < pm, 4'($urandom_range(0, 15)), $urandom,
              $urandom_range(0, 3) != 0, 4'($urandom_range(0, 15)), $urandom, acc);
      end
      idle(10);
      @(negedge clk);
      chk("drain_empty", 64'(exp_q.size()), 64'd0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule
